// File: rtl/iterative_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, WIDTH
// iterations, then a one-cycle ready strobe with quotient and exception flag.
// Optional remainder output enabled by defining DIV_REMAINDER_OUT_EN.
module iterative_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_OUT_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q_q, sign_q_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
`ifdef DIV_REMAINDER_OUT_EN
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] remout_q, remout_d;
`endif

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;

  // Operand magnitudes and the (WIDTH+1)-bit trial subtraction.
  always_comb begin
    a_abs  = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    b_abs  = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dsr_q};
  end

  // Next-state and datapath update; a start pulse in any state restarts.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sign_q_d = sign_q_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
`ifdef DIV_REMAINDER_OUT_EN
    sign_r_d = sign_r_q;
    remout_d = remout_q;
`endif
    if (ctrl_div) begin
      dvd_d    = a_abs;
      dsr_d    = b_abs;
      rem_d    = '0;
      quo_d    = '0;
      cnt_d    = '0;
      sign_q_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0_d   = (data_operandB == '0);
      ovf_d    = (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);
      result_d = '0;
      exc_d    = 1'b0;
      busy_d   = 1'b1;
`ifdef DIV_REMAINDER_OUT_EN
      sign_r_d = data_operandA[WIDTH-1];
      remout_d = '0;
`endif
      state_d  = (data_operandB == '0) ? DONE : ITER;
    end else begin
      case (state_q)
        ITER: begin
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IT) state_d = DONE;
        end
        DONE: begin
          result_d = div0_q ? '0 : (sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q);
          exc_d    = div0_q | ovf_q;
`ifdef DIV_REMAINDER_OUT_EN
          remout_d = (div0_q | ovf_q) ? '0 :
                     (sign_r_q ? (~rem_q + WIDTH'(1)) : rem_q);
`endif
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
      sign_r_q <= 1'b0;
      remout_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sign_q_q <= sign_q_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef DIV_REMAINDER_OUT_EN
      sign_r_q <= sign_r_d;
      remout_q <= remout_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
`ifdef DIV_REMAINDER_OUT_EN
  assign data_remainder = remout_q;
`endif

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=32): vector table plus
// hand sequences for abort, back-to-back accept and mid-operation reset.
module tb_iterative_divider;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    int           start;
    int           lat;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ctrl_div = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] res;
  logic         exc;
  logic         rdy;
  logic         busy;
`ifdef DIV_REMAINDER_OUT_EN
  logic [W-1:0] rem;
`endif

  iterative_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (res),
`ifdef DIV_REMAINDER_OUT_EN
    .data_remainder (rem),
`endif
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  exp_t sb[$];
  vec_t tv[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == '0) begin
      v.res = '0; v.rem = '0; v.exc = 1'b1; v.lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      v.res = 32'h8000_0000; v.rem = '0; v.exc = 1'b1; v.lat = 33;
    end else begin
      v.res = W'($signed(a) / $signed(b));
      v.rem = W'($signed(a) % $signed(b));
      v.exc = 1'b0;
      v.lat = 33;
    end
    return v;
  endfunction

  // Advance to the next falling edge and score any strobe seen there.
  task automatic sample();
    exp_t e;
    @(negedge clock);
    if (rdy) begin
      strobes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: rdy=1 at edge %0d, expected no strobe", cyc);
      end else begin
        e = sb.pop_front();
        check("result", res, e.res);
        check("exception", W'(exc), W'(e.exc));
`ifdef DIV_REMAINDER_OUT_EN
        check("remainder", rem, e.rem);
`endif
        check("latency", W'(cyc - e.start), W'(e.lat));
      end
    end
  endtask

  // Called at a falling edge: present a start pulse for the next rising edge.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                          input vec_t v);
    exp_t e;
    op_a = a;
    op_b = b;
    ctrl_div = 1'b1;
    if (push) begin
      e.res = v.res; e.rem = v.rem; e.exc = v.exc; e.start = cyc + 1; e.lat = v.lat;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    check("busy_on_accept", W'(busy), W'(1'b1));
    check("exc_cleared_on_accept", W'(exc), W'(1'b0));
    check("result_cleared_on_accept", res, '0);
  endtask

  // Wait (bounded) for the strobe, then check pulse width, idle and hold.
  task automatic wait_done(input logic [W-1:0] exp_res);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: no strobe within 100 cycles, expected one");
    end
    sample();
    check("rdy_single_cycle", W'(rdy), W'(1'b0));
    check("busy_after_done", W'(busy), W'(1'b0));
    sample();
    sample();
    check("result_held", res, exp_res);
  endtask

  initial begin
    vec_t v;
    int   s0;

    tv[0]  = '{a: 32'd100,         b: 32'd7,           res: 32'd14,         rem: 32'd2,          exc: 1'b0, lat: 33};
    tv[1]  = '{a: 32'hFFFF_FF9C,   b: 32'd7,           res: 32'hFFFF_FFF2,  rem: 32'hFFFF_FFFE,  exc: 1'b0, lat: 33};
    tv[2]  = '{a: 32'd100,         b: 32'hFFFF_FFF9,   res: 32'hFFFF_FFF2,  rem: 32'd2,          exc: 1'b0, lat: 33};
    tv[3]  = '{a: 32'd7,           b: 32'd0,           res: 32'd0,          rem: 32'd0,          exc: 1'b1, lat: 1};
    tv[4]  = '{a: 32'd9,           b: 32'd3,           res: 32'd3,          rem: 32'd0,          exc: 1'b0, lat: 33};
    tv[5]  = '{a: 32'h8000_0000,   b: 32'hFFFF_FFFF,   res: 32'h8000_0000,  rem: 32'd0,          exc: 1'b1, lat: 33};
    tv[6]  = '{a: 32'h8000_0000,   b: 32'd1,           res: 32'h8000_0000,  rem: 32'd0,          exc: 1'b0, lat: 33};
    tv[7]  = '{a: 32'd0,           b: 32'hFFFF_FFFB,   res: 32'd0,          rem: 32'd0,          exc: 1'b0, lat: 33};
    tv[8]  = '{a: 32'hFFFF_FFF9,   b: 32'hFFFF_FFFE,   res: 32'd3,          rem: 32'hFFFF_FFFF,  exc: 1'b0, lat: 33};
    tv[9]  = '{a: 32'h7FFF_FFFF,   b: 32'd2,           res: 32'h3FFF_FFFF,  rem: 32'd1,          exc: 1'b0, lat: 33};
    tv[10] = '{a: 32'hFFFF_FFFB,   b: 32'd100,         res: 32'd0,          rem: 32'hFFFF_FFFB,  exc: 1'b0, lat: 33};
    tv[11] = '{a: 32'd0,           b: 32'd0,           res: 32'd0,          rem: 32'd0,          exc: 1'b1, lat: 1};

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset_result", res, '0);
    check("reset_exception", W'(exc), W'(1'b0));
    check("reset_rdy", W'(rdy), W'(1'b0));
    check("reset_busy", W'(busy), W'(1'b0));
`ifdef DIV_REMAINDER_OUT_EN
    check("reset_remainder", rem, '0);
`endif
    reset_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      sample();
      drive_op(tv[i].a, tv[i].b, 1'b1, tv[i]);
      wait_done(tv[i].res);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = W'($urandom_range(1, 5000));
      if (i[0]) rb = ~rb + 32'd1;
      v = model(ra, rb);
      sample();
      drive_op(ra, rb, 1'b1, v);
      wait_done(v.res);
    end

    // New operation accepted in the same cycle as the strobe.
    sample();
    drive_op(32'd20, 32'd4, 1'b1, model(32'd20, 32'd4));
    for (int i = 0; i < 60; i++) begin
      sample();
      if (rdy) break;
    end
    drive_op(32'd21, 32'hFFFF_FFFD, 1'b1, model(32'd21, 32'hFFFF_FFFD));
    wait_done(32'hFFFF_FFF9);

    // Restart while busy: only the second operation strobes, 33 edges later.
    s0 = strobes;
    sample();
    drive_op(32'd1000, 32'd10, 1'b0, v);
    repeat (9) sample();
    drive_op(32'd50, 32'd5, 1'b1, model(32'd50, 32'd5));
    wait_done(32'd10);
    check("abort_single_strobe", W'(strobes - s0), W'(1));

    // Reset mid-operation drops the operation with no strobe.
    s0 = strobes;
    sample();
    drive_op(32'd1000, 32'd3, 1'b0, v);
    repeat (14) sample();
    @(posedge clock);
    #1;
    check("busy_before_reset", W'(busy), W'(1'b1));
    reset_n = 1'b0;
    #1;
    check("midreset_busy", W'(busy), W'(1'b0));
    check("midreset_rdy", W'(rdy), W'(1'b0));
    check("midreset_result", res, '0);
    check("midreset_exception", W'(exc), W'(1'b0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (40) sample();
    check("midreset_no_strobe", W'(strobes - s0), W'(0));
    sample();
    drive_op(32'd1000, 32'd3, 1'b1, model(32'd1000, 32'd3));
    wait_done(32'd333);

    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
